regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 92 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter
// Purpose : Round-robin owner of the register file write port (ALU vs. load)
//           with a pending-destination scoreboard for busy/WAW detection.
// Rev     : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int REG_WIDTH  = 34,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_alu_valid,
  input  logic [ADDR_WIDTH-1:0] i_alu_addr,
  input  logic [REG_WIDTH-1:0]  i_alu_data,
  output logic                  o_alu_ready,
  input  logic                  i_mem_valid,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic [REG_WIDTH-1:0]  i_mem_data,
  output logic                  o_mem_ready,
  input  logic                  i_reserve_en,
  input  logic [ADDR_WIDTH-1:0] i_reserve_addr,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_b,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_c,
  output logic [ADDR_WIDTH-1:0] o_address_reg_a,
  output logic                  o_wenable_reg_a,
  output logic [REG_WIDTH-1:0]  o_writedata_reg_a,
  output logic                  o_busy_b,
  output logic                  o_busy_c,
  output logic                  o_waw_hazard
);

  localparam int N_REGISTERS = 1 << ADDR_WIDTH;

  localparam logic [0:0] c_grant_alu = 1'b0;
  localparam logic [0:0] c_grant_mem = 1'b1;

  logic [0:0]             r_last_grant;
  logic [N_REGISTERS-1:0] r_pending;
  logic [N_REGISTERS-1:0] w_pending_next;
  logic                   w_alu_xfer;
  logic                   w_mem_xfer;
  logic                   w_any_xfer;
  logic [ADDR_WIDTH-1:0]  w_xfer_addr;
  logic [REG_WIDTH-1:0]   w_xfer_data;

  // rst_n gates the readies so nothing is granted while reset is held
  assign o_alu_ready = rst_n & i_alu_valid & (~i_mem_valid | (r_last_grant == c_grant_mem));
  assign o_mem_ready = rst_n & i_mem_valid & (~i_alu_valid | (r_last_grant == c_grant_alu));

  assign w_alu_xfer  = i_alu_valid & o_alu_ready;
  assign w_mem_xfer  = i_mem_valid & o_mem_ready;
  assign w_any_xfer  = w_alu_xfer | w_mem_xfer;
  assign w_xfer_addr = w_alu_xfer ? i_alu_addr : i_mem_addr;
  assign w_xfer_data = w_alu_xfer ? i_alu_data : i_mem_data;

  always_comb begin
    w_pending_next = r_pending;
    if (w_any_xfer) begin
      w_pending_next[w_xfer_addr] = 1'b0;
    end
    // A reservation on the same edge as a commit must leave the bit set
    if (i_reserve_en) begin
      w_pending_next[i_reserve_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant      <= c_grant_mem;
      r_pending         <= '0;
      o_wenable_reg_a   <= 1'b0;
      o_address_reg_a   <= '0;
      o_writedata_reg_a <= '0;
    end else begin
      r_pending       <= w_pending_next;
      o_wenable_reg_a <= w_any_xfer;
      if (w_any_xfer) begin
        r_last_grant      <= w_alu_xfer ? c_grant_alu : c_grant_mem;
        o_address_reg_a   <= w_xfer_addr;
        o_writedata_reg_a <= w_xfer_data;
      end
    end
  end

  assign o_busy_b     = r_pending[i_rd_addr_b];
  assign o_busy_c     = r_pending[i_rd_addr_c];
  assign o_waw_hazard = i_reserve_en & r_pending[i_reserve_addr];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_wb_arbiter
// Purpose : Directed self-checking bench for regfile_wb_arbiter.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int RW = 34;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [RW-1:0] alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] mem_data;
  logic          mem_ready;
  logic          reserve_en;
  logic [AW-1:0] reserve_addr;
  logic [AW-1:0] rd_b;
  logic [AW-1:0] rd_c;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic [RW-1:0] wr_data;
  logic          busy_b;
  logic          busy_c;
  logic          waw;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_alu_valid       (alu_valid),
    .i_alu_addr        (alu_addr),
    .i_alu_data        (alu_data),
    .o_alu_ready       (alu_ready),
    .i_mem_valid       (mem_valid),
    .i_mem_addr        (mem_addr),
    .i_mem_data        (mem_data),
    .o_mem_ready       (mem_ready),
    .i_reserve_en      (reserve_en),
    .i_reserve_addr    (reserve_addr),
    .i_rd_addr_b       (rd_b),
    .i_rd_addr_c       (rd_c),
    .o_address_reg_a   (wr_addr),
    .o_wenable_reg_a   (wr_en),
    .o_writedata_reg_a (wr_data),
    .o_busy_b          (busy_b),
    .o_busy_c          (busy_c),
    .o_waw_hazard      (waw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    reserve_en = 1'b0; reserve_addr = '0;
    rd_b = '0; rd_c = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset values, with both valids high to show readies are held low
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    alu_valid = 1'b1; mem_valid = 1'b1;
    #1;
    n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wen got=%b exp=0", wr_en); end
    n_tests++; if (wr_addr !== '0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", wr_addr); end
    n_tests++; if (wr_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", wr_data); end
    n_tests++; if ({alu_ready, mem_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", {alu_ready, mem_ready}); end
    n_tests++; if ({busy_b, busy_c} !== 2'b00) begin n_fail++; $display("FAIL reset_busy got=%b exp=00", {busy_b, busy_c}); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Both sources valid right after reset: ALU, MEM, ALU, MEM
  task automatic test_contention();
    logic exp_alu;
    apply_reset();
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 34'h1_0000_0011;
    mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 34'h3_0000_0022;
    for (int i = 0; i < 4; i++) begin
      exp_alu = (i % 2 == 0);
      #1;
      n_tests++; if (alu_ready !== exp_alu || mem_ready !== !exp_alu) begin
        n_fail++; $display("FAIL contend_ready[%0d] got alu=%b mem=%b exp alu=%b", i, alu_ready, mem_ready, exp_alu);
      end
      @(posedge clk); #1;
      n_tests++; if (wr_en !== 1'b1 || wr_addr !== (exp_alu ? 5'd1 : 5'd2) ||
                     wr_data !== (exp_alu ? 34'h1_0000_0011 : 34'h3_0000_0022)) begin
        n_fail++; $display("FAIL contend_write[%0d] got en=%b addr=%0d data=%h", i, wr_en, wr_addr, wr_data);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  // Lone MEM request is granted even though MEM was granted last
  task automatic test_mem_only();
    mem_valid = 1'b1; mem_addr = 5'd31; mem_data = 34'h0_DEAD_BEEF;
    #1;
    n_tests++; if ({alu_ready, mem_ready} !== 2'b01) begin n_fail++; $display("FAIL mem_only_ready got=%b exp=01", {alu_ready, mem_ready}); end
    @(posedge clk); #1;
    n_tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd31 || wr_data !== 34'h0_DEAD_BEEF) begin
      n_fail++; $display("FAIL mem_only_write got en=%b addr=%0d data=%h", wr_en, wr_addr, wr_data);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // Single ALU write: one-cycle strobe, then address/data hold
  task automatic test_alu_only();
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 34'h2_0000_00AA;
    #1;
    n_tests++; if ({alu_ready, mem_ready} !== 2'b10) begin n_fail++; $display("FAIL alu_only_ready got=%b exp=10", {alu_ready, mem_ready}); end
    @(posedge clk); #1;
    n_tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 34'h2_0000_00AA) begin
      n_fail++; $display("FAIL alu_only_write got en=%b addr=%0d data=%h", wr_en, wr_addr, wr_data);
    end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL alu_only_drop got=%b exp=0", wr_en); end
    n_tests++; if (wr_addr !== 5'd3 || wr_data !== 34'h2_0000_00AA) begin
      n_fail++; $display("FAIL alu_only_hold got addr=%0d data=%h exp addr=3 data=2000000aa", wr_addr, wr_data);
    end
    @(negedge clk);
  endtask

  // Reserve reg 7, then commit it and watch busy clear
  task automatic test_scoreboard();
    reserve_en = 1'b1; reserve_addr = 5'd7; rd_b = 5'd7; rd_c = 5'd7;
    #1;
    n_tests++; if (busy_b !== 1'b0 || waw !== 1'b0) begin n_fail++; $display("FAIL sb_pre got busy_b=%b waw=%b exp 0 0", busy_b, waw); end
    @(negedge clk);
    reserve_en = 1'b0;
    #1;
    n_tests++; if ({busy_b, busy_c} !== 2'b11) begin n_fail++; $display("FAIL sb_busy got=%b exp=11", {busy_b, busy_c}); end
    rd_c = 5'd8;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 34'h0_0000_0777;
    #1;
    n_tests++; if ({busy_b, busy_c} !== 2'b10) begin n_fail++; $display("FAIL sb_busy_c_other got=%b exp=10", {busy_b, busy_c}); end
    @(posedge clk); #1;
    n_tests++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL sb_clear got=%b exp=0", busy_b); end
    n_tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd7) begin n_fail++; $display("FAIL sb_commit got en=%b addr=%0d", wr_en, wr_addr); end
    @(negedge clk);
    idle_inputs();
  endtask

  // Reserve and commit reg 9 on one edge; set wins, then WAW on re-reserve
  task automatic test_same_edge();
    reserve_en = 1'b1; reserve_addr = 5'd9; rd_b = 5'd9;
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 34'h1_2345_6789;
    #1;
    n_tests++; if (waw !== 1'b0) begin n_fail++; $display("FAIL same_edge_no_waw got=%b exp=0", waw); end
    @(negedge clk);
    alu_valid = 1'b0; reserve_en = 1'b0;
    #1;
    n_tests++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL same_edge_set_wins got=%b exp=1", busy_b); end
    reserve_en = 1'b1;
    #1;
    n_tests++; if (waw !== 1'b1) begin n_fail++; $display("FAIL same_edge_waw got=%b exp=1", waw); end
    @(negedge clk);
    reserve_en = 1'b0;
    #1;
    n_tests++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL same_edge_stays got=%b exp=1", busy_b); end
  endtask

  // Unreserved write to reg 0 is performed and leaves pending[0] clear
  task automatic test_unreserved_zero();
    rd_b = 5'd0; rd_c = 5'd9;
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 34'h3_FFFF_FFFF;
    @(posedge clk); #1;
    n_tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd0 || wr_data !== 34'h3_FFFF_FFFF) begin
      n_fail++; $display("FAIL unres_write got en=%b addr=%0d data=%h", wr_en, wr_addr, wr_data);
    end
    n_tests++; if ({busy_b, busy_c} !== 2'b01) begin n_fail++; $display("FAIL unres_busy got=%b exp=01", {busy_b, busy_c}); end
    @(negedge clk);
    mem_valid = 1'b0;
  endtask

  // Async reset mid-strobe, then ALU wins first contention
  task automatic test_async_reset();
    rd_b = 5'd9; rd_c = 5'd9;
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 34'h0_0000_0044;
    @(posedge clk); #1;
    n_tests++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL async_pre_wen got=%b exp=1", wr_en); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL async_wen_drop got=%b exp=0", wr_en); end
    n_tests++; if ({busy_b, busy_c} !== 2'b00) begin n_fail++; $display("FAIL async_busy got=%b exp=00", {busy_b, busy_c}); end
    n_tests++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL async_ready got=%b exp=0", mem_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 34'h0_0000_0055;
    #1;
    n_tests++; if ({alu_ready, mem_ready} !== 2'b10) begin n_fail++; $display("FAIL async_first_grant got=%b exp=10", {alu_ready, mem_ready}); end
    @(posedge clk); #1;
    n_tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd5) begin n_fail++; $display("FAIL async_first_write got en=%b addr=%0d", wr_en, wr_addr); end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_contention();
    test_mem_only();
    test_alu_only();
    test_scoreboard();
    test_same_edge();
    test_unreserved_zero();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
